// File: rtl/poker_types.sv
// Shared card encodings, card geometry and the slot record used by the
// pixel-pipeline stages around the card renderer.
package poker_types;

    typedef enum logic [3:0] {
        ACE   = 4'd0,
        TWO   = 4'd1,
        THREE = 4'd2,
        FOUR  = 4'd3,
        FIVE  = 4'd4,
        SIX   = 4'd5,
        SEVEN = 4'd6,
        EIGHT = 4'd7,
        NINE  = 4'd8,
        TEN   = 4'd9,
        JACK  = 4'd10,
        QUEEN = 4'd11,
        KING  = 4'd12
    } rank_t;

    typedef enum logic [1:0] {
        SPADES   = 2'd0,
        DIAMONDS = 2'd1,
        CLUBS    = 2'd2,
        HEARTS   = 2'd3
    } suit_t;

    typedef struct packed {
        rank_t rank;
        suit_t suit;
    } card_t;

    localparam int CARD_W = 48;
    localparam int CARD_H = 64;
    localparam int TEXT_W = 16;
    localparam int TEXT_H = 32;

    typedef struct packed {
        logic  occupied;
        logic  face_up;
        card_t card;
    } slot_t;

endpackage

// File: rtl/card_slot_hit.sv
// Combinational hit test of one pixel against one card slot rectangle
// and its rank/suit text box.
import poker_types::*;

module card_slot_hit #(
    parameter int TEXT_OFF_X = 4,
    parameter int TEXT_OFF_Y = 4
) (
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [10:0] org_x,
    input  logic [10:0] org_y,
    input  slot_t       slot,
    output logic        hit,
    output logic        text_hit,
    output logic [10:0] rel_x,
    output logic [10:0] rel_y,
    output card_t       card
);

    logic [10:0] tx;
    logic [10:0] ty;

    // Bit 10 is the sign of the 11-bit difference: set means left/above.
    always_comb begin
        rel_x = {1'b0, DrawX} - org_x;
        rel_y = {1'b0, DrawY} - org_y;
        tx    = rel_x - 11'(TEXT_OFF_X);
        ty    = rel_y - 11'(TEXT_OFF_Y);
        hit   = slot.occupied
              && !rel_x[10] && (rel_x < 11'(CARD_W))
              && !rel_y[10] && (rel_y < 11'(CARD_H));
        text_hit = hit && slot.face_up
              && !tx[10] && (tx < 11'(TEXT_W))
              && !ty[10] && (ty < 11'(TEXT_H));
        card  = slot.card;
    end

endmodule

// File: rtl/card_slot_locator.sv
// Double-buffered card slot table with frame-start commit and a
// registered per-pixel slot lookup feeding the card text renderer.
import poker_types::*;

module card_slot_locator #(
    parameter int NUM_SLOTS  = 5,
    parameter int SLOT_X0    = 160,
    parameter int SLOT_PITCH = 64,
    parameter int SLOT_Y0    = 320,
    parameter int TEXT_OFF_X = 4,
    parameter int TEXT_OFF_Y = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       frame_start,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_clear,
    input  logic       wr_en_slot,
    input  logic [2:0] wr_slot,
    input  card_t      wr_card,
    input  logic       wr_face_up,
    output logic       wr_err,
    output logic       commit_done,
    output card_t      card_out,
    output logic [3:0] font_x,
    output logic [4:0] font_y,
    output logic       card_body,
    output logic       card_back,
    output logic       text_region
);

    slot_t       staged [NUM_SLOTS];
    slot_t       active [NUM_SLOTS];
    logic        dirty;
    logic        accept;
    logic        slot_ok;
    logic        hit      [NUM_SLOTS];
    logic        text_hit [NUM_SLOTS];
    logic [10:0] rel_x    [NUM_SLOTS];
    logic [10:0] rel_y    [NUM_SLOTS];
    card_t       card     [NUM_SLOTS];
    logic        found;
    logic [2:0]  sel;

    // Writes stall in the commit cycle so staged is stable while copied.
    assign wr_ready = Reset_n && !frame_start;
    assign accept   = wr_valid && wr_ready;
    assign slot_ok  = {1'b0, wr_slot} < 4'(NUM_SLOTS);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                staged[i] <= '0;
                active[i] <= '0;
            end
            dirty       <= 1'b0;
            wr_err      <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            wr_err      <= accept && wr_en_slot && !slot_ok;
            commit_done <= frame_start && dirty;
            if (frame_start && dirty) begin
                active <= staged;
                dirty  <= 1'b0;
            end
            if (accept) begin
                if (wr_clear) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        staged[i].occupied <= 1'b0;
                    end
                end
                if (wr_en_slot && slot_ok) begin
                    staged[wr_slot] <= '{1'b1, wr_face_up, wr_card};
                end
                dirty <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        card_slot_hit #(
            .TEXT_OFF_X(TEXT_OFF_X),
            .TEXT_OFF_Y(TEXT_OFF_Y)
        ) u_hit (
            .DrawX   (DrawX),
            .DrawY   (DrawY),
            .org_x   (11'(SLOT_X0 + g * SLOT_PITCH)),
            .org_y   (11'(SLOT_Y0)),
            .slot    (active[g]),
            .hit     (hit[g]),
            .text_hit(text_hit[g]),
            .rel_x   (rel_x[g]),
            .rel_y   (rel_y[g]),
            .card    (card[g])
        );
    end

    // Scan downward so the lowest hitting index is the one left in sel.
    always_comb begin
        found = 1'b0;
        sel   = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found = 1'b1;
                sel   = 3'(i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            card_out    <= '0;
            font_x      <= '0;
            font_y      <= '0;
            card_body   <= 1'b0;
            card_back   <= 1'b0;
            text_region <= 1'b0;
        end else if (found) begin
            card_out    <= card[sel];
            card_body   <= 1'b1;
            card_back   <= !active[sel].face_up;
            text_region <= text_hit[sel];
            font_x      <= text_hit[sel] ? 4'(rel_x[sel] - 11'(TEXT_OFF_X)) : 4'd0;
            font_y      <= text_hit[sel] ? 5'(rel_y[sel] - 11'(TEXT_OFF_Y)) : 5'd0;
        end else begin
            font_x      <= '0;
            font_y      <= '0;
            card_body   <= 1'b0;
            card_back   <= 1'b0;
            text_region <= 1'b0;
        end
    end

endmodule

// File: tb/tb_card_slot_locator.sv
// Self-checking bench for card_slot_locator: directed table, hand-written
// handshake/commit sequences and random traffic against a geometric model.
import poker_types::*;

module tb_card_slot_locator;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       frame_start;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_clear;
    logic       wr_en_slot;
    logic [2:0] wr_slot;
    card_t      wr_card;
    logic       wr_face_up;
    logic       wr_err;
    logic       commit_done;
    card_t      card_out;
    logic [3:0] font_x;
    logic [4:0] font_y;
    logic       card_body;
    logic       card_back;
    logic       text_region;

    always #5 Clk = ~Clk;

    card_slot_locator dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .frame_start(frame_start),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_clear   (wr_clear),
        .wr_en_slot (wr_en_slot),
        .wr_slot    (wr_slot),
        .wr_card    (wr_card),
        .wr_face_up (wr_face_up),
        .wr_err     (wr_err),
        .commit_done(commit_done),
        .card_out   (card_out),
        .font_x     (font_x),
        .font_y     (font_y),
        .card_body  (card_body),
        .card_back  (card_back),
        .text_region(text_region)
    );

    typedef struct {
        bit occ;
        bit face;
        int rank;
        int suit;
    } mslot_t;

    typedef struct {
        int x;
        int y;
        int body;
        int back;
        int text;
        int fx;
        int fy;
    } vec_t;

    localparam int NS = 5;

    mslot_t m_stg [NS];
    mslot_t m_act [NS];
    bit     m_dirty;
    int     m_card;
    int     e_body, e_back, e_text, e_fx, e_fy, e_err, e_cd;
    int     checks = 0;
    int     errors = 0;
    vec_t   tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model one clock edge from the inputs currently driven, then compare.
    task automatic cycle(input bit px);
        int  x, y, fi, tx, ty, x0;
        bit  found, accept;
        #1;
        chk("wr_ready", int'(wr_ready), int'(Reset_n && !frame_start));
        x = int'(DrawX);
        y = int'(DrawY);
        if (!Reset_n) begin
            for (int i = 0; i < NS; i++) begin
                m_stg[i].occ = 0;
                m_act[i].occ = 0;
            end
            m_dirty = 0;
            m_card  = 0;
            e_body = 0; e_back = 0; e_text = 0;
            e_fx = 0; e_fy = 0; e_err = 0; e_cd = 0;
        end else begin
            found = 0;
            fi    = 0;
            for (int i = 0; i < NS; i++) begin
                x0 = 160 + 64 * i;
                if (!found && m_act[i].occ && x >= x0 && x < x0 + 48
                    && y >= 320 && y < 384) begin
                    found = 1;
                    fi    = i;
                end
            end
            e_body = 0; e_back = 0; e_text = 0; e_fx = 0; e_fy = 0;
            if (found) begin
                tx     = x - (160 + 64 * fi) - 4;
                ty     = y - 320 - 4;
                e_body = 1;
                e_back = m_act[fi].face ? 0 : 1;
                if (m_act[fi].face && tx >= 0 && tx < 16 && ty >= 0 && ty < 32) begin
                    e_text = 1;
                    e_fx   = tx;
                    e_fy   = ty;
                end
                m_card = m_act[fi].rank * 4 + m_act[fi].suit;
            end
            accept = wr_valid && !frame_start;
            e_err  = (accept && wr_en_slot && wr_slot >= 3'(NS)) ? 1 : 0;
            e_cd   = (frame_start && m_dirty) ? 1 : 0;
            if (frame_start && m_dirty) begin
                m_act   = m_stg;
                m_dirty = 0;
            end
            if (accept) begin
                if (wr_clear)
                    for (int i = 0; i < NS; i++) m_stg[i].occ = 0;
                if (wr_en_slot && int'(wr_slot) < NS) begin
                    m_stg[wr_slot].occ  = 1;
                    m_stg[wr_slot].face = wr_face_up;
                    m_stg[wr_slot].rank = int'(wr_card.rank);
                    m_stg[wr_slot].suit = int'(wr_card.suit);
                end
                m_dirty = 1;
            end
        end
        @(posedge Clk);
        #1;
        chk("wr_err", int'(wr_err), e_err);
        chk("commit_done", int'(commit_done), e_cd);
        if (px) begin
            chk("card_body", int'(card_body), e_body);
            chk("card_back", int'(card_back), e_back);
            chk("text_region", int'(text_region), e_text);
            chk("font_x", int'(font_x), e_fx);
            chk("font_y", int'(font_y), e_fy);
            chk("card_out", int'(card_out), m_card);
        end
    endtask

    task automatic wr(input bit clr, input bit en, input int slot,
                      input int rank, input int suit, input bit face);
        wr_valid   = 1;
        wr_clear   = clr;
        wr_en_slot = en;
        wr_slot    = 3'(slot);
        wr_card    = card_t'({4'(rank), 2'(suit)});
        wr_face_up = face;
        cycle(1);
        wr_valid   = 0;
        wr_clear   = 0;
    endtask

    task automatic commit();
        frame_start = 1;
        cycle(1);
        frame_start = 0;
    endtask

    task automatic px(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        cycle(1);
    endtask

    initial begin
        Reset_n = 0; DrawX = 0; DrawY = 0; frame_start = 0;
        wr_valid = 0; wr_clear = 0; wr_en_slot = 0; wr_slot = 0;
        wr_card = '0; wr_face_up = 0;
        for (int i = 0; i < NS; i++) begin
            m_stg[i] = '{0, 0, 0, 0};
            m_act[i] = '{0, 0, 0, 0};
        end
        m_dirty = 0;
        m_card  = 0;

        tbl[0]  = '{165, 330, 1, 0, 1, 1, 6};
        tbl[1]  = '{207, 383, 1, 0, 0, 0, 0};
        tbl[2]  = '{208, 383, 0, 0, 0, 0, 0};
        tbl[3]  = '{207, 384, 0, 0, 0, 0, 0};
        tbl[4]  = '{180, 324, 1, 0, 0, 0, 0};
        tbl[5]  = '{290, 340, 1, 1, 0, 0, 0};
        tbl[6]  = '{164, 324, 1, 0, 1, 0, 0};
        tbl[7]  = '{179, 355, 1, 0, 1, 15, 31};
        tbl[8]  = '{163, 324, 1, 0, 0, 0, 0};
        tbl[9]  = '{159, 330, 0, 0, 0, 0, 0};
        tbl[10] = '{224, 330, 0, 0, 0, 0, 0};
        tbl[11] = '{165, 319, 0, 0, 0, 0, 0};

        // Reset, including a write held during reset that must not land.
        px(164, 324);
        wr(0, 1, 0, 12, 3, 1);
        Reset_n = 1;
        px(164, 324);
        chk("post_reset_body", int'(card_body), 0);

        // Staged only: invisible until a commit.
        wr(0, 1, 0, 12, 3, 1);
        px(165, 330);
        chk("staged_hidden", int'(card_body), 0);
        commit();
        chk("commit_pulse", int'(commit_done), 1);
        px(165, 330);
        chk("commit_once", int'(commit_done), 0);
        chk("king_hearts", int'(card_out), 12 * 4 + 3);
        commit();

        // Face-down slot 2, then the directed geometry table.
        wr(0, 1, 2, 4, 2, 0);
        commit();
        foreach (tbl[k]) begin
            px(tbl[k].x, tbl[k].y);
            chk($sformatf("tbl%0d_body", k), int'(card_body), tbl[k].body);
            chk($sformatf("tbl%0d_back", k), int'(card_back), tbl[k].back);
            chk($sformatf("tbl%0d_text", k), int'(text_region), tbl[k].text);
            chk($sformatf("tbl%0d_fx", k), int'(font_x), tbl[k].fx);
            chk($sformatf("tbl%0d_fy", k), int'(font_y), tbl[k].fy);
        end

        // Request held across a commit cycle transfers the cycle after.
        DrawX = 10'(360); DrawY = 10'(340);
        wr_valid = 1; wr_en_slot = 1; wr_slot = 3; wr_clear = 0;
        wr_card = card_t'({4'd1, 2'd1}); wr_face_up = 1;
        frame_start = 1;
        #1;
        chk("ready_low_commit", int'(wr_ready), 0);
        cycle(1);
        frame_start = 0;
        cycle(1);
        wr_valid = 0;
        commit();
        px(360, 340);
        chk("held_write_body", int'(card_body), 1);

        // Out-of-range slot: error pulse, nothing written.
        wr(0, 1, 6, 7, 0, 1);
        chk("err_pulse", int'(wr_err), 1);
        px(100, 100);
        chk("err_once", int'(wr_err), 0);
        commit();
        for (int i = 0; i < NS; i++) px(180 + 64 * i, 350);

        // Clear then write slot 1 only.
        wr(1, 1, 1, 9, 0, 1);
        commit();
        for (int i = 0; i < NS; i++) px(180 + 64 * i, 350);
        px(230, 330);
        chk("ten_spades", int'(card_out), 9 * 4 + 0);

        // Reset mid-frame discards everything.
        wr(0, 1, 4, 3, 3, 1);
        Reset_n = 0;
        px(230, 330);
        chk("midreset_body", int'(card_body), 0);
        chk("midreset_card", int'(card_out), 0);
        Reset_n = 1;
        commit();
        px(230, 330);
        chk("midreset_gone", int'(card_body), 0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r < 3) begin
                wr(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
                   $urandom_range(0, 7), $urandom_range(0, 12),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end else if (r == 3) begin
                commit();
            end else if (r == 4) begin
                wr_valid = 1; wr_en_slot = 1; wr_clear = 0;
                wr_slot = 3'($urandom_range(0, 4));
                wr_card = card_t'({4'($urandom_range(0, 12)), 2'($urandom_range(0, 3))});
                wr_face_up = 1'($urandom_range(0, 1));
                frame_start = 1;
                cycle(1);
                frame_start = 0;
                cycle(1);
                wr_valid = 0;
            end else if (r == 5 && $urandom_range(0, 15) == 0) begin
                Reset_n = 0;
                cycle(1);
                Reset_n = 1;
            end else begin
                px($urandom_range(150, 480), $urandom_range(310, 395));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
